// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory-port signals shared between the
// pipeline, the unified memory and mem_arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_cancel;
    logic [DATA_W-1:0] if_data;
    logic              if_done;

    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall_if;
    logic              stall_mem;

    // Arbiter view: it serves both requesters and drives the memory port.
    modport slave (
        input  if_req, if_addr, if_cancel,
        input  d_req, d_wr, d_addr, d_wdata,
        input  mem_rdata,
        output if_data, if_done,
        output d_rdata, d_done,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output stall_if, stall_mem
    );

    // Pipeline-plus-memory view of the same bundle.
    modport master (
        output if_req, if_addr, if_cancel,
        output d_req, d_wr, d_addr, d_wdata,
        output mem_rdata,
        input  if_data, if_done,
        input  d_rdata, d_done,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// the memory stage; data has fixed priority, fetches can be cancelled.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic [1:0]        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              owner_q,     owner_d;
    logic              kill_q,      kill_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_wr_q,    mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_data_q,   if_data_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              if_done_q,   if_done_d;
    logic              d_done_q,    d_done_d;

    logic cancel_hit;
    logic fetch_killed;

    // A cancel only matters while a fetch owns the memory; in IDLE it merely
    // masks fetch sampling.
    assign cancel_hit   = (state_q != S_IDLE) && (owner_q == OWN_FETCH) && bus.if_cancel;
    assign fetch_killed = kill_q | cancel_hit;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        kill_d      = kill_q | cancel_hit;
        mem_en_d    = 1'b0;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_data_d   = if_data_q;
        d_rdata_d   = d_rdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                kill_d = 1'b0;
                if (bus.d_req) begin
                    state_d     = S_ISSUE;
                    owner_d     = OWN_DATA;
                    mem_en_d    = 1'b1;
                    mem_wr_d    = bus.d_wr;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                end else if (bus.if_req && !bus.if_cancel) begin
                    state_d    = S_ISSUE;
                    owner_d    = OWN_FETCH;
                    mem_en_d   = 1'b1;
                    mem_wr_d   = 1'b0;
                    mem_addr_d = bus.if_addr;
                end
            end

            S_ISSUE: begin
                cnt_d   = CNT_W'(MEM_LAT - 1);
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Read data is valid exactly in this cycle; the done pulse
                    // is registered so it appears in the DONE cycle.
                    state_d = S_DONE;
                    if (owner_q == OWN_DATA) begin
                        d_done_d = 1'b1;
                        if (!mem_wr_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                    end else if (!fetch_killed) begin
                        if_done_d = 1'b1;
                        if_data_d = bus.mem_rdata;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                kill_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            owner_q     <= OWN_FETCH;
            kill_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_data_q   <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge value of every other one.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            kill_q      <= kill_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_data_q   <= if_data_d;
            d_rdata_q   <= d_rdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_data   = if_data_q;
    assign bus.if_done   = if_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_done    = d_done_q;

    // Stalls drop in the done cycle so the pipeline register loads on its edge.
    assign bus.stall_if  = bus.if_req & ~if_done_q;
    assign bus.stall_mem = bus.d_req  & ~d_done_q;
endmodule
